// File: rtl/difftest_pkg.sv
// Shared types and helpers for the difftest commit queue.
// commit_entry_t describes the record layout for the default 32-bit, 32-register build.
package difftest_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NR_GPR_DEF = 32;
    localparam int GW         = $clog2(NR_GPR_DEF);

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         inst;
        logic                wen;
        logic [GW-1:0]       rd;
        logic [XLEN_DEF-1:0] wdata;
    } commit_entry_t;

    // Bit offset of element i in a flat vector of w-bit elements.
    function automatic int gpr_idx(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/difftest_fifo.sv
// Circular buffer that accepts up to NR_CH entries per cycle and releases one.
// Pointers carry an extra wrap bit so occupancy is a plain subtraction.
module difftest_fifo #(
    parameter int DEPTH = 8,
    parameter int NR_CH = 2,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1,
    localparam int CW   = $clog2(NR_CH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CW-1:0]      push_cnt,
    input  logic [NR_CH*W-1:0] push_data,
    input  logic               pop,
    output logic [W-1:0]       head,
    output logic [AW:0]        occupancy
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [AW-1:0] slot [NR_CH];

    for (genvar gi = 0; gi < NR_CH; gi++) begin : g_slot
        assign slot[gi] = wr_ptr_reg[AW-1:0] + AW'(gi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PW'(push_cnt);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // Storage needs no reset: the pointers alone decide what is live.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NR_CH; j++) begin
            if (j < int'(push_cnt))
                mem[slot[j]] <= push_data[j*W +: W];
        end
    end

    assign head      = mem[rd_ptr_reg[AW-1:0]];
    assign occupancy = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/difftest_commit_queue.sv
// Buffers in-order commits, advances a shadow GPR file and presents one commit per handshake.
module difftest_commit_queue
    import difftest_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NR_GPR = NR_GPR_DEF,
    parameter int NR_CH  = 2,
    parameter int DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NR_CH-1:0]                  cmt_valid,
    input  logic [NR_CH*XLEN-1:0]             cmt_pc,
    input  logic [NR_CH*32-1:0]               cmt_inst,
    input  logic [NR_CH-1:0]                  cmt_wen,
    input  logic [NR_CH*$clog2(NR_GPR)-1:0]   cmt_rd,
    input  logic [NR_CH*XLEN-1:0]             cmt_wdata,
    output logic                              cmt_ready,
    output logic                              chk_valid,
    input  logic                              chk_ready,
    output logic [XLEN-1:0]                   chk_pc,
    output logic [31:0]                       chk_inst,
    output logic [NR_GPR*XLEN-1:0]            chk_gpr,
    output logic [31:0]                       chk_seq,
    output logic                              overflow,
    output logic [$clog2(DEPTH):0]            occupancy
);

    localparam int RW = $clog2(NR_GPR);
    localparam int CW = $clog2(NR_CH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] wdata;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t             ch_ent [NR_CH];
    logic [NR_CH*EW-1:0] comp;
    logic [CW-1:0]      comp_cnt;
    logic [CW-1:0]      push_cnt;
    logic [EW-1:0]      head_raw;
    entry_t             head_e;
    logic               load;

    logic               chk_valid_reg;
    logic [XLEN-1:0]    chk_pc_reg;
    logic [31:0]        chk_inst_reg;
    logic [31:0]        chk_seq_reg;
    logic [31:0]        seq_reg;
    logic               overflow_reg;
    logic [XLEN-1:0]    gpr_reg [NR_GPR];

    for (genvar gi = 0; gi < NR_CH; gi++) begin : g_ch
        assign ch_ent[gi] = '{pc:    cmt_pc[gi*XLEN +: XLEN],
                              inst:  cmt_inst[gi*32 +: 32],
                              wen:   cmt_wen[gi],
                              rd:    cmt_rd[gi*RW +: RW],
                              wdata: cmt_wdata[gi*XLEN +: XLEN]};
    end

    // Pack valid channels into consecutive slots, oldest first.
    always_comb begin
        comp     = '0;
        comp_cnt = '0;
        for (int j = 0; j < NR_CH; j++) begin
            if (cmt_valid[j]) begin
                comp[int'(comp_cnt)*EW +: EW] = ch_ent[j];
                comp_cnt = comp_cnt + CW'(1);
            end
        end
    end

    assign cmt_ready = int'(occupancy) <= DEPTH - NR_CH;
    assign push_cnt  = cmt_ready ? comp_cnt : '0;
    assign head_e    = entry_t'(head_raw);
    assign load      = (occupancy != '0) && (!chk_valid_reg || chk_ready);

    difftest_fifo #(
        .DEPTH (DEPTH),
        .NR_CH (NR_CH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_cnt  (push_cnt),
        .push_data (comp),
        .pop       (load),
        .head      (head_raw),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_valid_reg <= 1'b0;
            chk_pc_reg    <= '0;
            chk_inst_reg  <= '0;
            chk_seq_reg   <= '0;
            seq_reg       <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (load) begin
                chk_valid_reg <= 1'b1;
                chk_pc_reg    <= head_e.pc;
                chk_inst_reg  <= head_e.inst;
                chk_seq_reg   <= seq_reg;
                seq_reg       <= seq_reg + 32'd1;
            end else if (chk_ready) begin
                chk_valid_reg <= 1'b0;
            end
            if (|cmt_valid && !cmt_ready)
                overflow_reg <= 1'b1;
        end
    end

    // The shadow file only moves on a load, so it doubles as the presented snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_GPR; i++)
                gpr_reg[i] <= '0;
        end else if (load && head_e.wen && head_e.rd != '0) begin
            gpr_reg[head_e.rd] <= head_e.wdata;
        end
    end

    for (genvar gi = 0; gi < NR_GPR; gi++) begin : g_gpr
        assign chk_gpr[gpr_idx(gi, XLEN) +: XLEN] = gpr_reg[gi];
    end

    assign chk_valid = chk_valid_reg;
    assign chk_pc    = chk_pc_reg;
    assign chk_inst  = chk_inst_reg;
    assign chk_seq   = chk_seq_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Randomised bench for difftest_commit_queue with a queue-based reference model
// plus directed literal checks on reset, ordering, x0, backpressure, overflow and mid-stream reset.
module tb_difftest_commit_queue;

    localparam int XLEN = 32, NR_GPR = 32, NR_CH = 2, DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   cmt_valid = '0;
    logic [63:0]  cmt_pc = '0;
    logic [63:0]  cmt_inst = '0;
    logic [1:0]   cmt_wen = '0;
    logic [9:0]   cmt_rd = '0;
    logic [63:0]  cmt_wdata = '0;
    logic         cmt_ready;
    logic         chk_valid;
    logic         chk_ready = 1'b1;
    logic [31:0]  chk_pc;
    logic [31:0]  chk_inst;
    logic [1023:0] chk_gpr;
    logic [31:0]  chk_seq;
    logic         overflow;
    logic [3:0]   occupancy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    difftest_commit_queue #(
        .XLEN(XLEN), .NR_GPR(NR_GPR), .NR_CH(NR_CH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
        .cmt_wen(cmt_wen), .cmt_rd(cmt_rd), .cmt_wdata(cmt_wdata),
        .cmt_ready(cmt_ready),
        .chk_valid(chk_valid), .chk_ready(chk_ready),
        .chk_pc(chk_pc), .chk_inst(chk_inst), .chk_gpr(chk_gpr), .chk_seq(chk_seq),
        .overflow(overflow), .occupancy(occupancy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } rec_t;

    rec_t        q[$];
    rec_t        r;
    logic [31:0] mgpr [32];
    logic        m_valid, m_ovf;
    logic [31:0] m_pc, m_inst, m_seq, m_next;
    int          m_pre;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 32; i++) mgpr[i] = '0;
            m_valid = 1'b0; m_ovf = 1'b0;
            m_pc = '0; m_inst = '0; m_seq = '0; m_next = '0;
        end else begin
            m_pre = q.size();
            if (m_valid && chk_ready)
                $display("xfer seq=%0d pc=%08h inst=%08h", m_seq, m_pc, m_inst);
            if (m_pre > 0 && (!m_valid || chk_ready)) begin
                r = q.pop_front();
                if (r.wen && r.rd != 0) mgpr[r.rd] = r.wdata;
                m_valid = 1'b1; m_pc = r.pc; m_inst = r.inst;
                m_seq = m_next; m_next = m_next + 1;
            end else if (chk_ready) begin
                m_valid = 1'b0;
            end
            if (m_pre <= DEPTH - NR_CH) begin
                for (int c = 0; c < NR_CH; c++) begin
                    if (cmt_valid[c]) begin
                        r.pc = cmt_pc[c*32 +: 32]; r.inst = cmt_inst[c*32 +: 32];
                        r.wen = cmt_wen[c]; r.rd = cmt_rd[c*5 +: 5]; r.wdata = cmt_wdata[c*32 +: 32];
                        q.push_back(r);
                    end
                end
            end else if (|cmt_valid) begin
                m_ovf = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int bad;
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("cmt_ready", 32'(cmt_ready), 32'(q.size() <= DEPTH - NR_CH));
            chk("chk_valid", 32'(chk_valid), 32'(m_valid));
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            bad = -1;
            for (int i = 0; i < 32; i++)
                if (bad < 0 && chk_gpr[i*32 +: 32] !== mgpr[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL gpr x%0d got %h expected %h", bad, chk_gpr[bad*32 +: 32], mgpr[bad]);
            end
            if (m_valid) begin
                chk("chk_pc", chk_pc, m_pc);
                chk("chk_inst", chk_inst, m_inst);
                chk("chk_seq", chk_seq, m_seq);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ch(input int c, input logic [31:0] pc, input logic [31:0] inst,
                          input logic wen, input logic [4:0] rd, input logic [31:0] wd);
        cmt_pc[c*32 +: 32]    = pc;
        cmt_inst[c*32 +: 32]  = inst;
        cmt_wen[c]            = wen;
        cmt_rd[c*5 +: 5]      = rd;
        cmt_wdata[c*32 +: 32] = wd;
    endtask

    task automatic do_reset();
        cmt_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        bit done = 1'b0;
        chk_ready = 1'b1;
        cmt_valid = '0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (occupancy == 0 && !chk_valid) done = 1'b1;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    int acc;
    int rp;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst cmt_ready", 32'(cmt_ready), 32'd1);
        chk("rst chk_valid", 32'(chk_valid), 32'd0);
        chk("rst occupancy", 32'(occupancy), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // single commit, two-edge latency
        set_ch(0, 32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 32'd5);
        cmt_valid = 2'b01;
        @(negedge clk);
        cmt_valid = 2'b00;
        chk("t1 early valid", 32'(chk_valid), 32'd0);
        @(negedge clk);
        chk("t1 valid", 32'(chk_valid), 32'd1);
        chk("t1 pc", chk_pc, 32'h8000_0000);
        chk("t1 x1", chk_gpr[32 +: 32], 32'd5);
        chk("t1 seq", chk_seq, 32'd0);

        // dual commit to the same register, same cycle
        do_reset();
        set_ch(0, 32'h8000_0010, 32'h0070_0113, 1'b1, 5'd2, 32'd7);
        set_ch(1, 32'h8000_0014, 32'h0090_0113, 1'b1, 5'd2, 32'd9);
        cmt_valid = 2'b11;
        @(negedge clk);
        cmt_valid = 2'b00;
        @(negedge clk);
        chk("t2 first x2", chk_gpr[64 +: 32], 32'd7);
        chk("t2 first seq", chk_seq, 32'd0);
        @(negedge clk);
        chk("t2 second x2", chk_gpr[64 +: 32], 32'd9);
        chk("t2 second seq", chk_seq, 32'd1);
        chk("t2 second pc", chk_pc, 32'h8000_0014);

        // write to x0 is ignored
        set_ch(0, 32'h8000_0020, 32'h0000_0013, 1'b1, 5'd0, 32'hDEAD_BEEF);
        cmt_valid = 2'b01;
        @(negedge clk);
        cmt_valid = 2'b00;
        @(negedge clk);
        chk("t3 valid", 32'(chk_valid), 32'd1);
        chk("t3 x0", chk_gpr[0 +: 32], 32'd0);

        // backpressure: fill while respecting cmt_ready
        do_reset();
        chk_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (!cmt_ready) break;
            set_ch(0, 32'h1000 + 32'(4*i), 32'h13 + 32'(i), 1'b1, 5'(i + 1), 32'(3*i + 1));
            cmt_valid = 2'b01;
            @(negedge clk);
            acc++;
        end
        cmt_valid = 2'b00;
        @(negedge clk);
        chk("bp accepted", 32'(acc), 32'd8);
        chk("bp occupancy", 32'(occupancy), 32'd7);
        chk("bp cmt_ready", 32'(cmt_ready), 32'd0);
        chk("bp overflow", 32'(overflow), 32'd0);
        chk("bp seq", chk_seq, 32'd0);
        chk("bp pc", chk_pc, 32'h1000);

        // overflow while full-ish
        set_ch(0, 32'h2000, 32'h13, 1'b1, 5'd9, 32'd99);
        cmt_valid = 2'b01;
        @(negedge clk);
        cmt_valid = 2'b00;
        chk("ovf set", 32'(overflow), 32'd1);
        chk("ovf occupancy", 32'(occupancy), 32'd7);
        @(negedge clk);
        chk("ovf sticky", 32'(overflow), 32'd1);
        drain("ovf drain");
        chk("ovf after drain", 32'(overflow), 32'd1);

        // mid-stream asynchronous reset
        do_reset();
        chk("mr overflow cleared", 32'(overflow), 32'd0);
        chk_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_ch(0, 32'h3000 + 32'(4*i), 32'h93, 1'b1, 5'(i + 3), 32'(i + 100));
            cmt_valid = 2'b01;
            @(negedge clk);
        end
        cmt_valid = 2'b00;
        @(negedge clk);
        chk("mr pre occupancy", 32'(occupancy), 32'd5);
        chk("mr pre valid", 32'(chk_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr valid", 32'(chk_valid), 32'd0);
        chk("mr pc", chk_pc, 32'd0);
        chk("mr inst", chk_inst, 32'd0);
        chk("mr seq", chk_seq, 32'd0);
        chk("mr gpr nonzero", 32'(|chk_gpr), 32'd0);
        chk("mr occupancy", 32'(occupancy), 32'd0);
        rst_n = 1'b1;
        chk_ready = 1'b1;
        @(negedge clk);
        set_ch(0, 32'h4000, 32'h00A0_0093, 1'b1, 5'd1, 32'd10);
        cmt_valid = 2'b01;
        @(negedge clk);
        cmt_valid = 2'b00;
        @(negedge clk);
        chk("mr next valid", 32'(chk_valid), 32'd1);
        chk("mr next seq", chk_seq, 32'd0);
        chk("mr next x1", chk_gpr[32 +: 32], 32'd10);

        // randomised traffic with varying checker backpressure
        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 4)
                0: rp = 90;
                1: rp = 25;
                2: rp = 60;
                default: rp = 100;
            endcase
            chk_ready = ($urandom_range(0, 99) < rp);
            for (int ch = 0; ch < NR_CH; ch++)
                set_ch(ch, $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            cmt_valid = cmt_ready ? 2'($urandom) : 2'b00;
            @(negedge clk);
        end
        drain("final drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
